// File: rtl/count_step_monitor_if.sv
`default_nettype none
// =============================================================================
// count_step_monitor_if : counter-in / step-out bundle of count_step_monitor
// Rev 1.0
// =============================================================================
interface count_step_monitor_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       Count_In;
    logic             Sel;
    logic             Step_Ready;
    logic             Step_Valid;
    logic [3:0]       Step_Value;
    logic             Step_Dir;
    logic             Wrap_Pulse;
    logic             Err_Pulse;
    logic [CNT_W-1:0] Wrap_Count;
    logic [CNT_W-1:0] Err_Count;
    logic             Overrun;

    modport master (
        output Count_In, Sel, Step_Ready,
        input  Step_Valid, Step_Value, Step_Dir, Wrap_Pulse, Err_Pulse,
        input  Wrap_Count, Err_Count, Overrun
    );

    modport slave (
        input  Count_In, Sel, Step_Ready,
        output Step_Valid, Step_Value, Step_Dir, Wrap_Pulse, Err_Pulse,
        output Wrap_Count, Err_Count, Overrun
    );
endinterface
`default_nettype wire

// File: rtl/count_step_monitor.sv
`default_nettype none
// =============================================================================
// count_step_monitor : synchronise, debounce and classify ripple-counter steps
// Rev 1.0
// =============================================================================
module count_step_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  wire logic             CLK,
    input  wire logic             Reset,
    count_step_monitor_if.slave   bus
);
    localparam logic [2:0]       STABLE    = 3'(STABLE_CYCLES);
    localparam logic [2:0]       STABLE_M1 = 3'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       cin_s1, cin_s2, cand, acc;
    logic             sel_s1, sel_s2, sel_prev;
    logic [2:0]       run;
    logic [3:0]       delta;
    logic             accept, sel_chg;
    logic             load_acc, step, wrap, err;
    logic             step_valid, step_dir, wrap_pulse, err_pulse, overrun;
    logic [3:0]       step_value;
    logic [CNT_W-1:0] wrap_count, err_count;

    assign delta   = cin_s2 - acc;
    assign sel_chg = (sel_s2 != sel_prev);

    // Accept on the cycle the run counter reaches STABLE; a fresh value only
    // qualifies immediately when a single sample is enough.
    always_comb begin
        accept = 1'b0;
        if (cin_s2 != cand)
            accept = (STABLE == 3'd1);
        else
            accept = (run == STABLE_M1);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A direction change outranks a simultaneous accept, which then serves as the resync load.
    always_comb begin
        state_next = state;
        load_acc   = 1'b0;
        step       = 1'b0;
        wrap       = 1'b0;
        err        = 1'b0;
        if (sel_chg) begin
            state_next = RESYNC;
            if (accept) begin
                load_acc   = 1'b1;
                state_next = TRACK;
            end
        end else if (accept) begin
            case (state)
                IDLE, RESYNC: begin
                    load_acc   = 1'b1;
                    state_next = TRACK;
                end
                TRACK: begin
                    if (sel_s2 && delta == 4'd1) begin
                        step     = 1'b1;
                        load_acc = 1'b1;
                        wrap     = (cin_s2 == 4'd0);
                    end else if (!sel_s2 && delta == 4'd15) begin
                        step     = 1'b1;
                        load_acc = 1'b1;
                        wrap     = (cin_s2 == 4'd15);
                    end else if (delta != 4'd0) begin
                        err      = 1'b1;
                        load_acc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cin_s1     <= '0;
            cin_s2     <= '0;
            sel_s1     <= 1'b0;
            sel_s2     <= 1'b0;
            sel_prev   <= 1'b0;
            cand       <= '0;
            run        <= '0;
            acc        <= '0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
            step_valid <= 1'b0;
            step_value <= '0;
            step_dir   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cin_s1   <= bus.Count_In;
            cin_s2   <= cin_s1;
            sel_s1   <= bus.Sel;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;

            if (cin_s2 != cand) begin
                cand <= cin_s2;
                run  <= 3'd1;
            end else if (run < STABLE) begin
                run  <= run + 3'd1;
            end

            if (load_acc)
                acc <= cin_s2;

            wrap_pulse <= wrap;
            err_pulse  <= err;
            if (wrap && wrap_count != CNT_MAX)
                wrap_count <= wrap_count + 1'b1;
            if (err && err_count != CNT_MAX)
                err_count <= err_count + 1'b1;

            // Full buffer with Ready high swaps in the new step in the same edge.
            if (step) begin
                if (!step_valid || bus.Step_Ready) begin
                    step_valid <= 1'b1;
                    step_value <= cin_s2;
                    step_dir   <= sel_s2;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (bus.Step_Ready) begin
                step_valid <= 1'b0;
            end
        end
    end

    assign bus.Step_Valid = step_valid;
    assign bus.Step_Value = step_value;
    assign bus.Step_Dir   = step_dir;
    assign bus.Wrap_Pulse = wrap_pulse;
    assign bus.Err_Pulse  = err_pulse;
    assign bus.Wrap_Count = wrap_count;
    assign bus.Err_Count  = err_count;
    assign bus.Overrun    = overrun;
endmodule
`default_nettype wire
